cp0_exception_unit: RTL

Coprocessor-0 and exception sequencer for the 5-stage MIPS pipeline. It supplies the fetch redirect (epc_ctrl/epc) and MFC0 read data (cp_Cdata) to the datapath, and consumes the datapath's CP0 address, MTC0 write data and resume PC. It holds Status, Cause, EPC, Count and Compare. It arbitrates syscall, reserved-instruction, external and timer interrupts, and sequences trap entry and ERET return with a two-cycle flush/redirect protocol.

---
 rtl/cp0_exception_unit_pkg.sv | 26 ++
 rtl/cp0_int_sync.sv | 24 ++
 rtl/cp0_exception_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, register bit positions, sequencer states.
package cp0_exception_unit_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP2     = 10;
    localparam int CAUSE_TI      = 30;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_REDIRECT_TRAP = 2'd1,
        ST_REDIRECT_RET  = 2'd2
    } state_t;

endpackage

// File: rtl/cp0_int_sync.sv
// Multi-flop synchronizer for the asynchronous external interrupt level.
// Latency STAGES cycles; no backpressure, short pulses may be dropped.
module cp0_int_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], din};
        end
    end

    assign dout = sr[STAGES-1];

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file plus trap/ERET sequencer: flush in the take cycle, redirect the next cycle.
// MFC0 reads are combinational; a stalled ID instruction has no architectural effect.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_int,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic        exc_syscall,
    input  logic        exc_ri,
    input  logic        eret,
    input  logic        mtc0_en,
    input  logic [4:0]  cp_addr_r,
    input  logic [31:0] cp_Gdata,
    input  logic [31:0] cp0_return_addr,
    output logic [31:0] cp_Cdata,
    output logic        epc_ctrl,
    output logic [31:0] epc,
    output logic        flush
);

    logic        ie;
    logic        exl;
    logic        ti;
    logic        ip2;
    logic [4:0]  exc_code;
    logic [31:0] epc_r;
    logic [31:0] count;
    logic [31:0] compare;
    state_t      state;
    state_t      state_nxt;

    logic        ok;
    logic        int_pend;
    logic        take_trap;
    logic        take_eret;
    logic        wr_en;
    logic [4:0]  trap_code;

    cp0_int_sync #(.STAGES(SYNC_STAGES)) u_int_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ext_int),
        .dout (ip2)
    );

    // rst gates ok so the take-cycle flush is also forced low while reset is held.
    always_comb begin
        ok        = id_valid & ~id_stall & (state == ST_IDLE) & ~rst;
        int_pend  = (ip2 | ti) & ie & ~exl;
        take_trap = ok & (exc_ri | exc_syscall | int_pend);
        take_eret = ok & eret & ~take_trap;
        wr_en     = ok & mtc0_en & ~take_trap & ~eret;
        if (exc_ri) begin
            trap_code = EXC_RI;
        end else if (exc_syscall) begin
            trap_code = EXC_SYS;
        end else begin
            trap_code = EXC_INT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        epc_ctrl  = 1'b0;
        epc       = '0;
        flush     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take_trap) begin
                    state_nxt = ST_REDIRECT_TRAP;
                    flush     = 1'b1;
                end else if (take_eret) begin
                    state_nxt = ST_REDIRECT_RET;
                    flush     = 1'b1;
                end
            end
            ST_REDIRECT_TRAP: begin
                epc_ctrl  = 1'b1;
                epc       = HANDLER_ADDR;
                flush     = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_REDIRECT_RET: begin
                epc_ctrl  = 1'b1;
                epc       = epc_r;
                flush     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie       <= 1'b0;
            exl      <= 1'b0;
            ti       <= 1'b0;
            exc_code <= '0;
            epc_r    <= '0;
            count    <= '0;
            compare  <= 32'hFFFF_FFFF;
        end else begin
            if (wr_en && cp_addr_r == CP0_COUNT) begin
                count <= cp_Gdata;
            end else begin
                count <= count + 32'd1;
            end

            if (wr_en && cp_addr_r == CP0_COMPARE) begin
                compare <= cp_Gdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end

            // A nested trap keeps the original EPC so the outer handler can still return.
            if (take_trap) begin
                exc_code <= trap_code;
                exl      <= 1'b1;
                if (!exl) begin
                    epc_r <= cp0_return_addr;
                end
            end else if (take_eret) begin
                exl <= 1'b0;
            end else if (wr_en) begin
                case (cp_addr_r)
                    CP0_STATUS: begin
                        ie  <= cp_Gdata[STATUS_IE];
                        exl <= cp_Gdata[STATUS_EXL];
                    end
                    CP0_EPC: epc_r <= cp_Gdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp_Cdata = '0;
        case (cp_addr_r)
            CP0_STATUS: begin
                cp_Cdata[STATUS_IE]  = ie;
                cp_Cdata[STATUS_EXL] = exl;
            end
            CP0_CAUSE: begin
                cp_Cdata[CAUSE_EXC_LSB +: 5] = exc_code;
                cp_Cdata[CAUSE_IP2]          = ip2;
                cp_Cdata[CAUSE_TI]           = ti;
            end
            CP0_EPC:     cp_Cdata = epc_r;
            CP0_COUNT:   cp_Cdata = count;
            CP0_COMPARE: cp_Cdata = compare;
            default:     cp_Cdata = '0;
        endcase
    end

endmodule
